// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// MEM-stage access controller sitting between the EX/MEM pipeline register and
// a byte-array data memory with a 32-bit big-endian word port (registered,
// one-cycle read latency; whole-word writes only).
//
// Executes LB/LBU/LH/LHU/LW/SB/SH/SW. Loads read one word and pick out the
// addressed byte or half, then sign- or zero-extend it. SB/SH have no byte
// enables to use, so they read the word, merge the new lane in and write the
// whole word back. req_ready doubles as the pipeline stall: it is high only
// while the unit is idle.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined     - a half access with addr[0]=1, or a word access with
//                 addr[1:0]!=0, completes as an error without touching memory.
//   not defined - misaligned low address bits are ignored (half uses addr[1],
//                 word is forced aligned); resp_error flags illegal ops only.
//
// Parameters
//   ADDR_BITS       physical byte-address bits forwarded to memory
//
// Ports
//   clock           rising-edge clock, shared with the data memory
//   reset           asynchronous, active-high
//   req_valid       request present (sampled only while req_ready=1)
//   req_ready       high iff the FSM is idle
//   req_store       1 = store, 0 = load
//   req_op[2:0]     000 byte, 001 half, 011 word, 100 byte-u, 101 half-u
//   req_addr[31:0]  effective byte address
//   req_wdata[31:0] store data, right-justified
//   resp_valid      one-cycle completion pulse
//   resp_error      qualified by resp_valid: illegal op / misaligned
//   load_data[31:0] extended load result, held until the next response
//   mem_address     word-aligned memory address, bits above ADDR_BITS zero
//   mem_read        memory read strobe
//   mem_write       memory write strobe
//   mem_write_data  word written to memory
//   mem_read_data   memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_BITS = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t      state;
  state_t      state_next;
  logic        wr_settle;
  logic        wr_settle_next;

  logic        op_store;
  logic [2:0]  op_code;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic        req_illegal;
  logic        req_misaligned;
  logic        accept;

  logic        resp_valid_next;
  logic        resp_error_next;
  logic [31:0] load_data_next;
  logic [31:0] mem_address_next;
  logic [31:0] mem_write_data_next;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  // Strobes and ready come straight from the state so they clear with it.
  // The write strobe covers only the first of the two WR cycles.
  assign req_ready = (state == IDLE);
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR) && !wr_settle;

  // Classify the incoming request. Unsigned sub-word ops only exist for loads.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_op)
      OP_B, OP_H, OP_W: req_illegal = 1'b0;
      OP_BU, OP_HU:     req_illegal = req_store;
      default:          req_illegal = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (req_op[1:0] == 2'b01) begin
      req_misaligned = req_addr[0];
    end else if (req_op == OP_W) begin
      req_misaligned = (req_addr[1:0] != 2'b00);
    end
`endif
  end

  // Lane handling on the word returned by memory. Big-endian: byte k lives in
  // bits [31-8k -: 8], the half at addr[1]=0 is the upper half. Loads extract
  // and extend; SB/SH splice the latched store data into the old word.
  always_comb begin
    rd_byte = 8'h00;
    case (op_lane)
      2'd0:    rd_byte = mem_read_data[31:24];
      2'd1:    rd_byte = mem_read_data[23:16];
      2'd2:    rd_byte = mem_read_data[15:8];
      default: rd_byte = mem_read_data[7:0];
    endcase
    rd_half = op_lane[1] ? mem_read_data[15:0] : mem_read_data[31:16];

    load_fmt = 32'h0;
    case (op_code)
      OP_B:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
      OP_BU:   load_fmt = {24'h0, rd_byte};
      OP_H:    load_fmt = {{16{rd_half[15]}}, rd_half};
      OP_HU:   load_fmt = {16'h0, rd_half};
      OP_W:    load_fmt = mem_read_data;
      default: load_fmt = 32'h0;
    endcase

    merged = mem_read_data;
    if (op_code == OP_B) begin
      case (op_lane)
        2'd0:    merged[31:24] = op_wdata[7:0];
        2'd1:    merged[23:16] = op_wdata[7:0];
        2'd2:    merged[15:8]  = op_wdata[7:0];
        default: merged[7:0]   = op_wdata[7:0];
      endcase
    end else if (op_code == OP_H) begin
      if (op_lane[1]) begin
        merged[15:0] = op_wdata;
      end else begin
        merged[31:16] = op_wdata;
      end
    end
  end

  // Next-state and registered-output logic.
  // WR spends two cycles: the first drives the write strobe, the second lets
  // the memory commit before the completion is reported, so the response
  // always arrives with the unit already idle and ready for the next access.
  always_comb begin
    state_next          = state;
    wr_settle_next      = 1'b0;
    accept              = 1'b0;
    resp_valid_next     = 1'b0;
    resp_error_next     = 1'b0;
    load_data_next      = load_data;
    mem_address_next    = mem_address;
    mem_write_data_next = mem_write_data;

    case (state)
      IDLE: begin
        if (req_valid) begin
          accept           = 1'b1;
          mem_address_next = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS-1:2], 2'b00};
          if (req_illegal || req_misaligned) begin
            state_next = ERR;
          end else if (req_store && (req_op == OP_W)) begin
            state_next          = WR;
            mem_write_data_next = req_wdata;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next = op_store ? MRG : CAP;
      end
      CAP: begin
        load_data_next  = load_fmt;
        resp_valid_next = 1'b1;
        state_next      = IDLE;
      end
      MRG: begin
        mem_write_data_next = merged;
        state_next          = WR;
      end
      WR: begin
        if (!wr_settle) begin
          wr_settle_next = 1'b1;
        end else begin
          resp_valid_next = 1'b1;
          state_next      = IDLE;
        end
      end
      ERR: begin
        resp_valid_next = 1'b1;
        resp_error_next = 1'b1;
        load_data_next  = 32'h0;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_settle <= 1'b0;
    end else begin
      state     <= state_next;
      wr_settle <= wr_settle_next;
    end
  end

  // Request latch and registered outputs. Only the low half of the store data
  // is kept for SB/SH; SW loads the full word into mem_write_data at accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_store       <= 1'b0;
      op_code        <= 3'b000;
      op_lane        <= 2'b00;
      op_wdata       <= 16'h0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      load_data      <= 32'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      if (accept) begin
        op_store <= req_store;
        op_code  <= req_op;
        op_lane  <= req_addr[1:0];
        op_wdata <= req_wdata[15:0];
      end
      resp_valid     <= resp_valid_next;
      resp_error     <= resp_error_next;
      load_data      <= load_data_next;
      mem_address    <= mem_address_next;
      mem_write_data <= mem_write_data_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Testbench for load_store_unit. A byte-array data memory with a registered
// big-endian word port sits on the memory side. Requests are issued through
// applyStimulus, which also runs a byte-level reference model and pushes the
// expected response into a scoreboard queue; an independent negedge monitor
// pops and compares whenever resp_valid is seen (error flag, load data,
// latency and the number of read/write strobes used by the access).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_BITS = 11;
  localparam int MEM_BYTES = 1 << ADDR_BITS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] load_data;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic        check_data;
    logic        err;
    logic [31:0] data;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  load_store_unit #(.ADDR_BITS(ADDR_BITS)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_error     (resp_error),
    .load_data      (load_data),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: whole-word big-endian write, registered read.
  always @(posedge clock) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        dmem[int'(mem_address[ADDR_BITS-1:0]) + i] <= mem_write_data[31-8*i -: 8];
      end
    end
    if (mem_read) begin
      mem_read_data <= {dmem[int'(mem_address[ADDR_BITS-1:0])],
                        dmem[int'(mem_address[ADDR_BITS-1:0]) + 1],
                        dmem[int'(mem_address[ADDR_BITS-1:0]) + 2],
                        dmem[int'(mem_address[ADDR_BITS-1:0]) + 3]};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference model: works on the byte array directly with plain arithmetic.
  task automatic model(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int     a;
    int     n;
    int     base;
    longint v;
    bit     illegal;
    bit     mis;
    a       = int'(addr & (MEM_BYTES - 1));
    illegal = (op == 3'b010) || (op == 3'b110) || (op == 3'b111) || (st && op[2]);
    n       = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (!illegal && (a % n) != 0) mis = 1'b1;
`endif
    e.acc = 0; e.err = 1'b0; e.data = 32'h0; e.check_data = 1'b0;
    e.nrd = 0; e.nwr = 0; e.lat = 0;
    base = a - (a % n);
    if (illegal || mis) begin
      e.err = 1'b1; e.check_data = 1'b1; e.data = 32'h0; e.lat = 1;
    end else if (!st) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[base + i]);
      if (!op[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
      e.data = v[31:0]; e.check_data = 1'b1; e.lat = 2; e.nrd = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = 8'((wd >> (8*(n-1-i))) & 32'hFF);
      e.lat = (n == 4) ? 2 : 4;
      e.nrd = (n == 4) ? 0 : 1;
      e.nwr = 1;
    end
  endtask

  // Drive a request and hold req_valid until the DUT is idle, then record the
  // expectation. req_valid stays high while the DUT is busy with the previous
  // access, so ignored requests are exercised on every back-to-back pair.
  task automatic applyStimulus(input logic st, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wd);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (!req_ready) begin
      fails++;
      $display("[TB] FAIL accept_timeout: req_ready 0 for %0d cycles, expected 1", waited);
      req_valid = 1'b0;
    end else begin
      model(st, op, addr, wd, e);
      e.acc = cyc;
      sbq.push_back(e);
      @(posedge clock);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    @(negedge clock);
    checkOutput("drain_pending", 32'(sbq.size()), 32'h0);
  endtask

  // Monitor: scoreboard pop and per-access strobe accounting.
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  exp_t m;
  always @(negedge clock) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read && mem_write) checkOutput("strobe_overlap", 32'h1, 32'h0);
      if (mem_read || mem_write)
        checkOutput("mem_address_form", mem_address & ~(32'(MEM_BYTES - 1) & 32'hFFFF_FFFC), 32'h0);
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_resp", 32'h1, 32'h0);
        end else begin
          m = sbq.pop_front();
          checkOutput("resp_error", 32'(resp_error), 32'(m.err));
          if (m.check_data) checkOutput("load_data", load_data, m.data);
          checkOutput("latency", 32'(cyc - m.acc - 1), 32'(m.lat));
          checkOutput("read_strobes", 32'(rd_cnt), 32'(m.nrd));
          checkOutput("write_strobes", 32'(wr_cnt), 32'(m.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [2:0]  op;
    logic        st;
    logic [31:0] addr;
    int          r;

    for (int i = 0; i < MEM_BYTES; i++) begin
      b = 8'($urandom());
      dmem[i]    <= b;
      ref_mem[i]  = b;
    end
    dmem[16] <= 8'h88; dmem[17] <= 8'h99; dmem[18] <= 8'hAA; dmem[19] <= 8'hBB;
    ref_mem[16] = 8'h88; ref_mem[17] = 8'h99; ref_mem[18] = 8'hAA; ref_mem[19] = 8'hBB;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_req_ready",      32'(req_ready),  32'h1);
    checkOutput("rst_resp_valid",     32'(resp_valid), 32'h0);
    checkOutput("rst_resp_error",     32'(resp_error), 32'h0);
    checkOutput("rst_mem_read",       32'(mem_read),   32'h0);
    checkOutput("rst_mem_write",      32'(mem_write),  32'h0);
    checkOutput("rst_load_data",      load_data,       32'h0);
    checkOutput("rst_mem_address",    mem_address,     32'h0);
    checkOutput("rst_mem_write_data", mem_write_data,  32'h0);
    reset = 1'b0;

    // Word load and sub-word loads of the preloaded word
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0); drain();
    checkOutput("lw_0x10_const", load_data, 32'h8899AABB);
    applyStimulus(1'b0, 3'b000, 32'h11, 32'h0); drain();
    checkOutput("lb_0x11_const", load_data, 32'hFFFFFF99);
    applyStimulus(1'b0, 3'b100, 32'h11, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0); drain();
    checkOutput("lh_0x12_const", load_data, 32'hFFFFAABB);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'h0); drain();
    checkOutput("lhu_0x10_const", load_data, 32'h00008899);

    // Read-modify-write stores
    applyStimulus(1'b1, 3'b000, 32'h13, 32'h000000CC);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0); drain();
    checkOutput("sb_then_lw_const", load_data, 32'h8899AACC);
    applyStimulus(1'b1, 3'b001, 32'h10, 32'h00001234);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0); drain();
    checkOutput("sh_then_lw_const", load_data, 32'h1234AACC);

    // Misaligned word and illegal op
    applyStimulus(1'b1, 3'b011, 32'h10, 32'h8899AABB);
    applyStimulus(1'b0, 3'b011, 32'h12, 32'h0); drain();
`ifdef MISALIGN_TRAP_EN
    checkOutput("lw_0x12_const", load_data, 32'h0);
`else
    checkOutput("lw_0x12_const", load_data, 32'h8899AABB);
`endif
    applyStimulus(1'b0, 3'b110, 32'h10, 32'h0); drain();
    checkOutput("illegal_op_load_data", load_data, 32'h0);

    // Reset during the merge cycle of an SB: no write, no response
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_op = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_mem_write", 32'(mem_write),  32'h0);
    checkOutput("abort_req_ready", 32'(req_ready),  32'h1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0); drain();
    checkOutput("abort_word_intact", load_data, 32'h8899AABB);

    // Randomized traffic, mostly legal, with some aliased high addresses
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 99);
      st = ($urandom_range(0, 2) == 0);
      if (r < 8) begin
        op = st ? 3'(4 + $urandom_range(0, 1)) : 3'((r % 3 == 0) ? 2 : (r % 3 == 1) ? 6 : 7);
      end else if (st) begin
        r  = $urandom_range(0, 2);
        op = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : 3'b011;
      end else begin
        r  = $urandom_range(0, 4);
        op = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b011 : (r == 3) ? 3'b100 : 3'b101;
      end
      addr = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 63)) : $urandom();
      applyStimulus(st, op, addr, $urandom());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
